ctrl_seq: RTL

Sequencer that drives the 7-bit input vector of the combinational control decoder and registers its 26-bit decoded control word. It sits directly upstream of the decoder: it accepts opcodes over a valid/ready handshake and steps a phase counter through the opcode's phases. Each cycle it presents {phase, opcode} to the decoder and captures the returned word into an output register with its own valid/ready handshake.

---
 rtl/ctrl_seq_pkg.sv | 27 ++
 rtl/ctrl_seq.sv | 131 +++++++++++++
 2 files changed

// File: rtl/ctrl_seq_pkg.sv
// ============================================================================
//  Module      : ctrl_seq_pkg
//  Description : Shared widths, state encoding and opcode helpers for ctrl_seq
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_seq_pkg;

    localparam int OP_W  = 4;
    localparam int PH_W  = 3;
    localparam int CW_W  = 26;
    localparam int DEC_W = PH_W + OP_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Index of the final phase; the opcode runs op_len(op)+1 phases.
    function automatic logic [PH_W-1:0] op_len(input logic [OP_W-1:0] op);
        return op[PH_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_seq.sv
// ============================================================================
//  Module      : ctrl_seq
//  Description : Phase sequencer feeding the control decoder and registering
//                its decoded control word behind a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_seq #(
    parameter int OP_W = ctrl_seq_pkg::OP_W,
    parameter int PH_W = ctrl_seq_pkg::PH_W,
    parameter int CW_W = ctrl_seq_pkg::CW_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    input  logic [OP_W-1:0]      cmd_op,
    output logic                 cmd_ready,
    input  logic                 abort,
    output logic [PH_W+OP_W-1:0] dec_in,
    input  logic [CW_W-1:0]      dec_out,
    output logic                 ctrl_valid,
    output logic [CW_W-1:0]      ctrl_word,
    output logic                 ctrl_last,
    input  logic                 ctrl_ready,
    output logic                 busy
);

    import ctrl_seq_pkg::*;

    state_e            state_q,      state_d;
    logic [OP_W-1:0]   op_q,         op_d;
    logic [PH_W-1:0]   phase_q,      phase_d;
    logic [PH_W-1:0]   len_q,        len_d;
    logic              ctrl_valid_q, ctrl_valid_d;
    logic [CW_W-1:0]   ctrl_word_q,  ctrl_word_d;
    logic              ctrl_last_q,  ctrl_last_d;

    logic w_run;
    logic w_slot_free;
    logic w_step;
    logic w_last;
    logic w_accept;

    assign w_run       = (state_q == RUN);
    assign w_slot_free = ~ctrl_valid_q | ctrl_ready;
    assign w_step      = w_run & w_slot_free & ~abort;
    assign w_last      = (phase_q == len_q);
    assign w_accept    = cmd_valid & cmd_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= '0;
            phase_q      <= '0;
            len_q        <= '0;
            ctrl_valid_q <= 1'b0;
            ctrl_word_q  <= '0;
            ctrl_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            phase_q      <= phase_d;
            len_q        <= len_d;
            ctrl_valid_q <= ctrl_valid_d;
            ctrl_word_q  <= ctrl_word_d;
            ctrl_last_q  <= ctrl_last_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        phase_d      = phase_q;
        len_d        = len_q;
        ctrl_valid_d = ctrl_valid_q;
        ctrl_word_d  = ctrl_word_q;
        ctrl_last_d  = ctrl_last_q;

        if (abort) begin
            // Flush wins over capture, accept and a same-cycle consumer pop.
            state_d      = IDLE;
            phase_d      = '0;
            ctrl_valid_d = 1'b0;
        end else begin
            if (w_step) begin
                ctrl_word_d  = dec_out;
                ctrl_last_d  = w_last;
                ctrl_valid_d = 1'b1;
                if (w_last) begin
                    state_d = IDLE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end else if (ctrl_ready) begin
                ctrl_valid_d = 1'b0;
            end

            // Accept overrides the last-step return to IDLE so that
            // consecutive opcodes run without a bubble.
            if (w_accept) begin
                state_d = RUN;
                op_d    = cmd_op;
                len_d   = op_len(cmd_op);
                phase_d = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready  = ~abort & (~w_run | (w_step & w_last));
        dec_in     = w_run ? {phase_q, op_q} : '0;
        busy       = w_run;
        ctrl_valid = ctrl_valid_q;
        ctrl_word  = ctrl_word_q;
        ctrl_last  = ctrl_last_q;
    end

endmodule

`default_nettype wire
